// File: rtl/famiclone_detector.sv
// famiclone_detector
//   Power-on CIRAM line grounding, new-style famiclone detection and console
//   region classification, all clocked from CPU M2.
//
//   After reset the CIRAM /CE and /A13 lines are grounded for INIT_CYCLES M2
//   cycles. Once that finishes, sampled PPU reads compare PPU A13 with the
//   /A13 readback: lines that agree in value (rather than being complements)
//   flag a new-style famiclone. In parallel, frame starts are found as the
//   first PPU read after a long read-free gap (vblank). The M2 count between
//   frame starts is classified as NTSC / PAL / Dendy and committed after
//   CONFIRM consecutive equal classifications.
//
// Ports
//   m2             in   CPU M2 clock
//   reset          in   asynchronous active-high reset
//   ppu_rd_in      in   PPU /RD (asynchronous to m2)
//   ppu_a13_in     in   PPU A13
//   ppu_not_a13_in in   /A13 as read back from the console
//   ground_lines   out  1 = drive CIRAM /CE and /A13 low
//   init_done      out  power-on grounding period finished
//   new_dendy      out  sticky new-style famiclone flag
//   region         out  0 NTSC, 1 PAL, 2 Dendy
//   region_valid   out  region has been committed
//   frame_strobe   out  one-cycle pulse on each detected frame start
module famiclone_detector #(
    parameter int unsigned INIT_CYCLES     = 15,
    parameter int unsigned A13_SAMPLES     = 3,
    parameter int unsigned IDLE_THRESH     = 64,
    parameter int unsigned PERIOD_W        = 17,
    parameter int unsigned MIN_PERIOD      = 25000,
    parameter int unsigned NTSC_PAL_SPLIT  = 31500,
    parameter int unsigned PAL_DENDY_SPLIT = 34350,
    parameter int unsigned MAX_PERIOD      = 40000,
    parameter int unsigned CONFIRM         = 2
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_rd_in,
    input  logic       ppu_a13_in,
    input  logic       ppu_not_a13_in,
    output logic       ground_lines,
    output logic       init_done,
    output logic       new_dendy,
    output logic [1:0] region,
    output logic       region_valid,
    output logic       frame_strobe
);

    localparam int unsigned INIT_W  = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam int unsigned A13_W   = (A13_SAMPLES > 0) ? $clog2(A13_SAMPLES + 1) : 1;
    localparam int unsigned IDLE_W  = (IDLE_THRESH > 0) ? $clog2(IDLE_THRESH + 1) : 1;
    localparam int unsigned MATCH_W = (CONFIRM > 0) ? $clog2(CONFIRM + 1) : 1;

    localparam logic [INIT_W-1:0]   INIT_LOAD = INIT_W'(INIT_CYCLES);
    localparam logic [A13_W-1:0]    A13_LOAD  = A13_W'(A13_SAMPLES);
    localparam logic [IDLE_W-1:0]   IDLE_MAX  = IDLE_W'(IDLE_THRESH);
    localparam logic [MATCH_W-1:0]  MATCH_MAX = MATCH_W'(CONFIRM);
    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] P_NP      = PERIOD_W'(NTSC_PAL_SPLIT);
    localparam logic [PERIOD_W-1:0] P_PD      = PERIOD_W'(PAL_DENDY_SPLIT);
    localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(MAX_PERIOD);

    typedef enum logic [1:0] {
        REG_NTSC  = 2'd0,
        REG_PAL   = 2'd1,
        REG_DENDY = 2'd2
    } region_e;

    // Synchronisers; the rd chain has one extra stage for falling-edge detect.
    logic [2:0] rd_sync_q;
    logic [1:0] a13_sync_q;
    logic [1:0] na13_sync_q;
    logic       rd_s, rd_prev, a13_s, na13_s, read_ev;

    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                init_done_q, init_done_d;
    logic [A13_W-1:0]    cnt_lo_q, cnt_lo_d;
    logic [A13_W-1:0]    cnt_hi_q, cnt_hi_d;
    logic                new_dendy_q, new_dendy_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                armed_q, armed_d;
    region_e             cand_q, cand_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    region_e             region_q, region_d;
    logic                valid_q, valid_d;
    logic                frame_start;
    region_e             cls;

    assign rd_s    = rd_sync_q[1];
    assign rd_prev = rd_sync_q[2];
    assign a13_s   = a13_sync_q[1];
    assign na13_s  = na13_sync_q[1];
    assign read_ev = rd_prev & ~rd_s;

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            rd_sync_q   <= '1;
            a13_sync_q  <= '0;
            na13_sync_q <= '0;
        end else begin
            rd_sync_q   <= {rd_sync_q[1:0], ppu_rd_in};
            a13_sync_q  <= {a13_sync_q[0], ppu_a13_in};
            na13_sync_q <= {na13_sync_q[0], ppu_not_a13_in};
        end
    end

    always_comb begin
        init_cnt_d  = init_cnt_q;
        cnt_lo_d    = cnt_lo_q;
        cnt_hi_d    = cnt_hi_q;
        new_dendy_d = new_dendy_q;
        idle_d      = idle_q;
        period_d    = period_q;
        armed_d     = armed_q;
        cand_d      = cand_q;
        match_d     = match_q;
        region_d    = region_q;
        valid_d     = valid_q;
        frame_start = 1'b0;
        cls         = REG_NTSC;

        if (init_cnt_q != '0) begin
            init_cnt_d = init_cnt_q - INIT_W'(1);
        end
        // Registered so init_done is low in reset even when INIT_CYCLES is 0.
        init_done_d = (init_cnt_d == '0);

        if (init_done_q) begin
            if (read_ev) begin
                // Genuine hardware drives complementary levels; equality means
                // the clone ties /A13 to A13.
                if ((cnt_lo_q != '0) && (cnt_hi_q != '0) && (a13_s == na13_s)) begin
                    new_dendy_d = 1'b1;
                end
                if (!a13_s && (cnt_lo_q != '0)) begin
                    cnt_lo_d = cnt_lo_q - A13_W'(1);
                end
                if (a13_s && (cnt_hi_q != '0)) begin
                    cnt_hi_d = cnt_hi_q - A13_W'(1);
                end
                frame_start = (idle_q == IDLE_MAX);
                idle_d      = '0;
            end else if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IDLE_W'(1);
            end

            if (period_q != '1) begin
                period_d = period_q + PERIOD_W'(1);
            end

            if (frame_start) begin
                // The start cycle itself is cycle 0 of the new frame.
                period_d = PERIOD_W'(1);
                armed_d  = 1'b1;
                if (armed_q) begin
                    if ((period_q < P_MIN) || (period_q >= P_MAX)) begin
                        match_d = '0;
                    end else begin
                        if (period_q < P_NP) begin
                            cls = REG_NTSC;
                        end else if (period_q < P_PD) begin
                            cls = REG_PAL;
                        end else begin
                            cls = REG_DENDY;
                        end
                        if (cls == cand_q) begin
                            if (match_q != MATCH_MAX) begin
                                match_d = match_q + MATCH_W'(1);
                            end
                        end else begin
                            cand_d  = cls;
                            match_d = MATCH_W'(1);
                        end
                        if (match_d == MATCH_MAX) begin
                            region_d = cls;
                            valid_d  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            init_cnt_q  <= INIT_LOAD;
            init_done_q <= 1'b0;
            cnt_lo_q    <= A13_LOAD;
            cnt_hi_q    <= A13_LOAD;
            new_dendy_q <= 1'b0;
            idle_q      <= '0;
            period_q    <= '0;
            armed_q     <= 1'b0;
            cand_q      <= REG_NTSC;
            match_q     <= '0;
            region_q    <= REG_NTSC;
            valid_q     <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            cnt_lo_q    <= cnt_lo_d;
            cnt_hi_q    <= cnt_hi_d;
            new_dendy_q <= new_dendy_d;
            idle_q      <= idle_d;
            period_q    <= period_d;
            armed_q     <= armed_d;
            cand_q      <= cand_d;
            match_q     <= match_d;
            region_q    <= region_d;
            valid_q     <= valid_d;
        end
    end

    assign ground_lines = ~init_done_q;
    assign init_done    = init_done_q;
    assign new_dendy    = new_dendy_q;
    assign region       = region_q;
    assign region_valid = valid_q;
    assign frame_strobe = frame_start;

endmodule
